// File: rtl/lif_layer_scheduler.sv
// Shared LIF update engine sequencing a layer of N neurons, one per cycle.
// Latency: start accepted at E0, neurons updated E1..EN, done pulses the cycle after EN.
// Backpressure: none; step_start is ignored (not queued) while busy.
module lif_layer_scheduler #(
    parameter int                     N      = 8,
    parameter int                     W      = 8,
    parameter int                     FRACT  = 4,
    parameter logic signed [W-1:0]    LAMBDA = 8'sd12,
    parameter logic signed [W-1:0]    INC    = 8'sd10,
    parameter logic signed [W-1:0]    THRESH = 8'sd16,
    localparam int                    IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_start,
    input  logic [N-1:0]        in_spk,
    input  logic                clear,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        out_spk,
    input  logic [IW-1:0]       rd_idx,
    output logic signed [W-1:0] rd_pot
);

    localparam int SW = 2 * W + 1;
    localparam logic signed [W-1:0] PMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] PMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic signed [W-1:0] pot [N];
    logic [N-1:0]        spk_in_q;
    logic [N-1:0]        spk_acc;

    logic signed [W-1:0]    cur_pot;
    logic                   cur_s;
    logic signed [2*W-1:0]  prod;
    logic signed [2*W-1:0]  leak;
    logic signed [SW-1:0]   inc_term;
    logic signed [SW-1:0]   sum;
    logic signed [W-1:0]    sat;
    logic                   fire;
    logic signed [W-1:0]    new_pot;
    logic [N-1:0]           spk_next;

    assign busy = (state != S_IDLE);

    // Select the neuron currently being updated and its captured input bit.
    always_comb begin
        cur_pot = '0;
        cur_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                cur_pot = pot[i];
                cur_s   = spk_in_q[i];
            end
        end
    end

    // Leak, integrate, saturate, then compare; reset-by-subtraction on fire.
    always_comb begin
        prod     = LAMBDA * cur_pot;
        leak     = prod >>> FRACT;
        inc_term = cur_s ? SW'(INC) : '0;
        sum      = SW'(leak) + inc_term;
        if (sum > SW'(PMAX)) begin
            sat = PMAX;
        end else if (sum < SW'(PMIN)) begin
            sat = PMIN;
        end else begin
            sat = sum[W-1:0];
        end
        fire    = (sat >= THRESH);
        new_pot = fire ? (sat - THRESH) : sat;
    end

    // Spike accumulator with the current neuron's result merged in, so the
    // final edge can publish all N bits at once.
    always_comb begin
        spk_next = spk_acc;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                spk_next[i] = fire;
            end
        end
    end

    // Combinational potential readout; indices past N-1 read as zero.
    always_comb begin
        rd_pot = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_pot = pot[i];
            end
        end
    end

    // Sequencer FSM and potential storage; clear aborts like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            done     <= 1'b0;
            out_spk  <= '0;
            spk_in_q <= '0;
            spk_acc  <= '0;
            for (int i = 0; i < N; i++) begin
                pot[i] <= '0;
            end
        end else if (clear) begin
            state    <= S_IDLE;
            idx      <= '0;
            done     <= 1'b0;
            out_spk  <= '0;
            spk_in_q <= '0;
            spk_acc  <= '0;
            for (int i = 0; i < N; i++) begin
                pot[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (step_start) begin
                        spk_in_q <= in_spk;
                        spk_acc  <= '0;
                        idx      <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IW'(i)) begin
                            pot[i] <= new_pot;
                        end
                    end
                    spk_acc <= spk_next;
                    if (idx == IW'(N - 1)) begin
                        out_spk <= spk_next;
                        done    <= 1'b1;
                        idx     <= '0;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
Time-multiplexed controller for one shared leaky-integrate-and-fire update datapath serving a layer of N neurons. Membrane potentials are held in an internal register array. On each timestep request, an FSM sequences the single LIF update across neurons 0..N-1, one neuron per cycle. It then publishes the layer's spike vector with a one-cycle done pulse. The block sits between the timestep/sequencing logic and downstream spike consumers.

Parameters:
N, 8, number of neurons in the layer (>=2)
W, 8, potential word width, signed fixed point Q(W-FRACT).FRACT
FRACT, 4, fractional bits
LAMBDA, 8'sd12, leak factor (0.75 in Q4.4), signed W bits, >=0
INC, 8'sd10, potential added per input spike (0.625 in Q4.4), signed W bits, >=0
THRESH, 8'sd16, firing threshold (1.0 in Q4.4), signed W bits, >0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
step_start  in  1  timestep request pulse; sampled only in IDLE
in_spk  in  N  input spike vector; captured on the edge that accepts step_start
clear  in  1  synchronous potential clear/abort
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, out_spk valid and updated
out_spk  out  N  spike vector of the last completed timestep; held until next done
rd_idx  in  clog2(N)  potential readout index
rd_pot  out  W  combinational P[rd_idx]; out-of-range index returns 0

Behaviour:
- Reset (rst_n=0, async): all P[i]=0, state=IDLE, idx=0, busy=0, done=0, out_spk=0, captured spikes=0.
- States:
  - IDLE -> RUN on step_start=1. Capture in_spk and set idx=0.
  - RUN: each edge updates neuron idx and increments idx. The edge with idx=N-1 moves to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Latency: start accepted at edge E0. Neurons are updated at edges E1..EN. At edge EN, out_spk is loaded with all N spike results. done=1 for exactly the cycle following EN (state DONE), then returns to 0.
- Throughput: one timestep per N+2 cycles.
- step_start asserted in RUN or DONE is ignored and not queued. in_spk changes after E0 have no effect.
- Per-neuron update for neuron i with captured input bit s:
  - prod = LAMBDA*P[i], full 2W signed.
  - leak = prod >>> FRACT (arithmetic shift, floor).
  - sum = leak + (s ? INC : 0), computed in 2W+1 bits.
  - Saturate sum to the W-bit signed range [-2^(W-1), 2^(W-1)-1].
  - If sat >= THRESH: spike bit i = 1, P[i] = sat - THRESH. Otherwise: bit i = 0, P[i] = sat.
  - Integrate happens before the compare, in the same update.
- Spike results accumulate in an internal N-bit register. out_spk changes only at EN, so partial results are never visible.
- clear=1 at any edge, in any state:
  - All P[i]=0, state=IDLE, idx=0, done=0, out_spk=0.
  - clear has priority over step_start in the same cycle; that step is not accepted.
- Reset asserted mid-RUN aborts identically to clear. No partial timestep is published.
- Neurons not yet reached when an abort occurs keep no stale update; all potentials are 0.

Test Plan:
- Constant drive: defaults, N=8, in_spk=8'hFF for 4 consecutive steps -> every neuron produces P sequence 10,1,10,1. out_spk=00,FF,00,FF. done once per step, exactly N+1 cycles after acceptance.
- Leak only: one step with in_spk=8'h01, then 6 steps with in_spk=0 -> rd_idx=0 reads 10,7,5,3,2,1,0. out_spk stays 0. Other neurons stay 0.
- Mixed vector and ordering: alternating in_spk=8'hA5 for two steps -> out_spk=A5 after step 2, 00 after step 1. Neurons with bits clear read 0.
- Handshake: step_start held high continuously -> steps accepted every N+2 cycles only. busy high N+1 cycles per step. Pulses during RUN/DONE produce no extra done.
- Saturation override: LAMBDA=16, INC=127, THRESH=127, constant input on neuron 0 -> step 1: 127 spike, P=0. Step 2: P=0 spike again. Forced 127+127 path saturates to 127, never wraps negative.
- Abort: clear asserted at cycle 3 of RUN (and separately rst_n pulsed mid-RUN) after potentials are nonzero -> all rd_pot=0, no done pulse, out_spk=0, busy=0 next cycle. The next step behaves as from reset.
